// File: rtl/timing_pkg.sv
// Shared types and helpers for the timing signal generator: run/halt state
// and the one-hot decode used to build the T0..Tn timing signals.
package timing_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam int MAX_SEL_W = 6;

  // Number of timing signals produced by a select of the given width.
  function automatic int num_t_f(input int sel_w);
    return 2 ** sel_w;
  endfunction

  // One-hot decode at the widest legal select; callers truncate to their width.
  function automatic logic [63:0] onehot_f(input logic [MAX_SEL_W-1:0] sel);
    return 64'd1 << sel;
  endfunction

endpackage

// File: rtl/decoder_n_to_2n.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder; all outputs low when en=0.
module decoder_n_to_2n
  import timing_pkg::*;
#(
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0]          sel,
  input  logic                      en,
  output logic [num_t_f(SEL_W)-1:0] onehot
);

  localparam int NUM_T = num_t_f(SEL_W);

  assign onehot = en ? NUM_T'(onehot_f(MAX_SEL_W'(sel))) : '0;

endmodule

// File: rtl/timing_signal_generator.sv
// Sequence counter with integrated one-hot decode producing registered timing
// signals, programmable terminal count, and load/clear/halt/start control.
module timing_signal_generator
  import timing_pkg::*;
#(
  parameter int SEL_W     = 4,
  parameter int MAX_COUNT = 2 ** SEL_W - 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic                      load,
  input  logic [SEL_W-1:0]          load_val,
  input  logic                      start,
  input  logic                      halt,
  output logic [SEL_W-1:0]          sc_out,
  output logic [num_t_f(SEL_W)-1:0] t_out,
  output logic                      running,
  output logic                      cycle_done,
  output logic                      load_err
);

  localparam int NUM_T = num_t_f(SEL_W);

  if (SEL_W < 1 || SEL_W > MAX_SEL_W) begin : g_bad_sel_w
    $error("timing_signal_generator: SEL_W must be in 1..6");
  end
  if (MAX_COUNT < 0 || MAX_COUNT > 2 ** SEL_W - 1) begin : g_bad_max_count
    $error("timing_signal_generator: MAX_COUNT must be <= 2**SEL_W-1");
  end

  localparam logic [SEL_W-1:0] MAX_SC = SEL_W'(MAX_COUNT);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sc_d;
  logic [NUM_T-1:0]   t_d;
  logic               cycle_done_d;
  logic               load_err_d;

  // Priority chain: clr > load > halt > start > en. Only the en branch can
  // wrap, so any higher-priority request suppresses cycle_done.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    sc_d         = sc_out;
    cycle_done_d = 1'b0;
    load_err_d   = 1'b0;
    if (clr) begin
      sc_d = '0;
    end else if (load) begin
      if (load_val <= MAX_SC) sc_d = load_val;
      else                    load_err_d = 1'b1;
    end else if (halt) begin
      state_d = ST_HALT;
    end else if (start) begin
      state_d = ST_RUN;
      sc_d    = '0;
    end else if (en && state_q == ST_RUN) begin
      if (sc_out == MAX_SC) begin
        sc_d         = '0;
        cycle_done_d = 1'b1;
      end else begin
        sc_d = sc_out + SEL_W'(1);
      end
    end
  end

  // Decode the next-state count so t_out and sc_out land on the same edge.
  decoder_n_to_2n #(
    .SEL_W (SEL_W)
  ) u_decoder (
    .sel    (sc_d),
    .en     (state_d == ST_RUN),
    .onehot (t_d)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample their next values together at the edge, independent of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      sc_out     <= '0;
      t_out      <= NUM_T'(1);
      cycle_done <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sc_out     <= sc_d;
      t_out      <= t_d;
      cycle_done <= cycle_done_d;
      load_err   <= load_err_d;
    end
  end

  assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_timing_signal_generator.sv
// Self-checking bench: four builds share one stimulus stream and are each
// compared every cycle against an arithmetic model, plus directed literals.
module tb_timing_signal_generator;

  localparam int N = 4;
  localparam int MAXC [N] = '{15, 4, 8, 1};
  localparam int SELW [N] = '{4, 4, 4, 1};

  logic clk = 1'b0;
  logic rst_n, en, clr, load, start, halt;
  logic [3:0] load_val;

  logic [3:0]  sc_a, sc_b, sc_c;
  logic [0:0]  sc_d;
  logic [15:0] t_a, t_b, t_c;
  logic [1:0]  t_d;
  logic [N-1:0] run_v, cd_v, le_v;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  timing_signal_generator #(.SEL_W(4), .MAX_COUNT(15)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .start(start), .halt(halt), .sc_out(sc_a),
    .t_out(t_a), .running(run_v[0]), .cycle_done(cd_v[0]), .load_err(le_v[0]));

  timing_signal_generator #(.SEL_W(4), .MAX_COUNT(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .start(start), .halt(halt), .sc_out(sc_b),
    .t_out(t_b), .running(run_v[1]), .cycle_done(cd_v[1]), .load_err(le_v[1]));

  timing_signal_generator #(.SEL_W(4), .MAX_COUNT(8)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .start(start), .halt(halt), .sc_out(sc_c),
    .t_out(t_c), .running(run_v[2]), .cycle_done(cd_v[2]), .load_err(le_v[2]));

  timing_signal_generator #(.SEL_W(1), .MAX_COUNT(1)) u_dut_d (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
    .load_val(load_val[0:0]), .start(start), .halt(halt), .sc_out(sc_d),
    .t_out(t_d), .running(run_v[3]), .cycle_done(cd_v[3]), .load_err(le_v[3]));

  // ---------------- behavioural model ----------------
  typedef struct {
    bit run;
    int sc;
    bit cd;
    bit le;
  } mdl_t;

  mdl_t mdl [N];

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.run = 1'b1; r.sc = 0; r.cd = 1'b0; r.le = 1'b0;
    return r;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, int maxc, int selw, bit c, bit l,
                                    int lv, bit h, bit s, bit e);
    mdl_t r;
    int   v;
    r    = m;
    r.cd = 1'b0;
    r.le = 1'b0;
    v    = lv % (1 << selw);
    if (c)                  r.sc = 0;
    else if (l && v <= maxc) r.sc = v;
    else if (l)             r.le = 1'b1;
    else if (h)             r.run = 1'b0;
    else if (s) begin
      r.run = 1'b1;
      r.sc  = 0;
    end else if (e && m.run) begin
      r.cd = (m.sc == maxc);
      r.sc = (m.sc + 1) % (maxc + 1);
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) mdl[i] <= mdl_reset();
      else mdl[i] <= mdl_next(mdl[i], MAXC[i], SELW[i], clr, load,
                              int'(load_val), halt, start, en);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(input string tag, input int i, input longint sc,
                            input longint t);
    longint exp_t;
    exp_t = mdl[i].run ? (longint'(1) << mdl[i].sc) : 64'd0;
    check({tag, "_sc"},  sc, longint'(mdl[i].sc));
    check({tag, "_t"},   t, exp_t);
    check({tag, "_run"}, longint'(run_v[i]), longint'(mdl[i].run));
    check({tag, "_cd"},  longint'(cd_v[i]),  longint'(mdl[i].cd));
    check({tag, "_le"},  longint'(le_v[i]),  longint'(mdl[i].le));
  endtask

  always @(negedge clk) begin
    check_inst("a", 0, longint'(sc_a), longint'(t_a));
    check_inst("b", 1, longint'(sc_b), longint'(t_b));
    check_inst("c", 2, longint'(sc_c), longint'(t_c));
    check_inst("d", 3, longint'(sc_d), longint'(t_d));
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit c, input bit l, input logic [3:0] lv,
                      input bit h, input bit s, input bit e);
    clr = c; load = l; load_val = lv; halt = h; start = s; en = e;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {en, clr, load, start, halt} = '0;
    load_val = '0;
    #12;
    check("rst_sc",  longint'(sc_a), 0);
    check("rst_t",   longint'(t_a), 64'h1);
    check("rst_run", longint'(run_v[0]), 1);
    check("rst_cd",  longint'(cd_v[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int i = 1; i <= 20; i++) begin
      step(0, 0, 4'd0, 0, 0, 1);
      if (i == 1)  check("d_alt_t", longint'(t_d), 64'h2);
      if (i == 5)  check("b_wrap_cd", longint'(cd_v[1]), 1);
      if (i == 15) check("a_t15", longint'(t_a), 64'h8000);
      if (i == 16) begin
        check("a_wrap_sc", longint'(sc_a), 0);
        check("a_wrap_cd", longint'(cd_v[0]), 1);
      end
      if (i == 20) check("a_sc20", longint'(sc_a), 4);
    end

    step(0, 1, 4'd7, 0, 0, 0);
    check("a_load7_t", longint'(t_a), 64'h80);
    check("b_load7_err", longint'(le_v[1]), 1);
    step(0, 1, 4'd9, 0, 0, 0);
    check("c_load9_sc", longint'(sc_c), 7);
    check("c_load9_err", longint'(le_v[2]), 1);
    step(0, 0, 4'd0, 0, 0, 0);
    check("c_err_pulse", longint'(le_v[2]), 0);

    step(0, 1, 4'd5, 0, 0, 0);
    step(0, 0, 4'd0, 1, 0, 1);
    check("a_halt_t", longint'(t_a), 0);
    check("a_halt_run", longint'(run_v[0]), 0);
    step(0, 0, 4'd0, 0, 0, 1);
    check("a_halt_hold", longint'(sc_a), 5);
    step(0, 0, 4'd0, 0, 1, 0);
    check("a_start_t", longint'(t_a), 64'h1);
    step(0, 0, 4'd0, 1, 1, 0);
    check("a_hs_run", longint'(run_v[0]), 0);

    step(0, 0, 4'd0, 0, 1, 0);
    step(0, 1, 4'd3, 0, 0, 0);
    step(1, 1, 4'd15, 0, 0, 1);
    check("a_clr_sc", longint'(sc_a), 0);
    step(0, 0, 4'd0, 1, 0, 0);
    step(0, 1, 4'd6, 0, 0, 0);
    step(1, 0, 4'd0, 0, 0, 0);
    check("a_clr_halt_t", longint'(t_a), 0);

    step(0, 0, 4'd0, 0, 1, 0);
    step(0, 1, 4'd11, 0, 0, 0);
    check("a_load11_t", longint'(t_a), 64'h800);
    {en, clr, load, start, halt} = '0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("a_mid_rst_sc", longint'(sc_a), 0);
    check("a_mid_rst_t", longint'(t_a), 64'h1);
    check("a_mid_rst_run", longint'(run_v[0]), 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) step(0, 0, 4'd0, 0, 0, 1);
    check("a_post_rst_sc", longint'(sc_a), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
